// File: rtl/button_debounce_pkg.sv
// ============================================================================
// Module      : button_debounce_pkg
// Description : Shared per-lane state encodings for debounce and one-pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package button_debounce_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_LOW  = 2'd0;
  localparam state_t S_RISE = 2'd1;
  localparam state_t S_HIGH = 2'd2;
  localparam state_t S_FALL = 2'd3;

endpackage : button_debounce_pkg

`default_nettype wire

// File: rtl/button_debounce_if.sv
// ============================================================================
// Module      : button_debounce_if
// Description : Raw button inputs and conditioned level/busy outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface button_debounce_if #(
  parameter int N_BTN = 4
);

  logic [N_BTN-1:0] pb_raw;
  logic [N_BTN-1:0] pb_debounced;
  logic [N_BTN-1:0] pb_busy;

  modport master (
    output pb_raw,
    input  pb_debounced,
    input  pb_busy
  );

  modport slave (
    input  pb_raw,
    output pb_debounced,
    output pb_busy
  );

endinterface : button_debounce_if

`default_nettype wire

// File: rtl/button_debounce_lane.sv
// ============================================================================
// Module      : debounce_lane
// Description : Single-bit 2-FF synchroniser, stability counter and FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_lane
  import button_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_raw,
  output logic      o_debounced,
  output logic      o_busy
);

  localparam int              CNT_W      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= S_LOW;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Any reversal while qualifying drops back and restarts from zero.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_LOW: begin
        if (r_sync2) begin
          w_state_next = S_RISE;
          w_cnt_next   = '0;
        end
      end
      S_RISE: begin
        if (!r_sync2) begin
          w_state_next = S_LOW;
          w_cnt_next   = '0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_next = S_HIGH;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (!r_sync2) begin
          w_state_next = S_FALL;
          w_cnt_next   = '0;
        end
      end
      default: begin
        if (r_sync2) begin
          w_state_next = S_HIGH;
          w_cnt_next   = '0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_next = S_LOW;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    o_debounced = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      S_LOW:   begin o_debounced = 1'b0; o_busy = 1'b0; end
      S_RISE:  begin o_debounced = 1'b0; o_busy = 1'b1; end
      S_HIGH:  begin o_debounced = 1'b1; o_busy = 1'b0; end
      default: begin o_debounced = 1'b1; o_busy = 1'b1; end
    endcase
  end

endmodule : debounce_lane

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module      : button_debounce
// Description : N_BTN independent debounce lanes feeding the one-pulse stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce #(
  parameter int N_BTN         = 4,
  parameter int STABLE_CYCLES = 1000000
) (
  input wire logic         clk,
  input wire logic         rst,
  button_debounce_if.slave bus
);

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_lane
    debounce_lane #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .i_raw      (bus.pb_raw[gi]),
      .o_debounced(bus.pb_debounced[gi]),
      .o_busy     (bus.pb_busy[gi])
    );
  end

endmodule : button_debounce

`default_nettype wire
